atpg_resp_checker: RTL and testbench

ATPG_RESP_CHECKER -- requirements
Module: atpg_resp_checker

---
 rtl/atpg_pkg.sv | 16 +
 rtl/atpg_misr.sv | 39 +++
 rtl/atpg_resp_checker.sv | 120 ++++++++++++
 tb/tb_atpg_resp_checker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atpg_pkg.sv
// Shared types and constants for the ATPG response checker: FSM state
// encoding, default response width and the MISR feedback taps.
package atpg_pkg;

    localparam int RESP_W_DEF = 26;

    // x^26 + x^6 + x^2 + x + 1 (the x^26 term is implied by the shift-out bit)
    localparam logic [RESP_W_DEF-1:0] MISR_TAPS = 26'h0000047;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/atpg_misr.sv
// Multiple-input signature register: shift/feedback compaction of every
// accepted response word, with a synchronous clear at the start of a run.
module atpg_misr
    import atpg_pkg::*;
#(
    parameter int                RESP_W = RESP_W_DEF,
    parameter logic [RESP_W-1:0] TAPS   = RESP_W'(MISR_TAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [RESP_W-1:0] data_i,
    output logic [RESP_W-1:0] sig_o
);

    logic [RESP_W-1:0] sig_q;
    logic [RESP_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = ({sig_q[RESP_W-2:0], 1'b0} ^ (sig_q[RESP_W-1] ? TAPS : '0)) ^ data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/atpg_resp_checker.sv
// Compares a stream of observed responses against a preloaded table of
// expected responses, counting mismatches and compacting into a MISR.
module atpg_resp_checker
    import atpg_pkg::*;
#(
    parameter  int RESP_W = RESP_W_DEF,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exp_wr_en,
    input  logic [AW-1:0]     exp_wr_addr,
    input  logic [RESP_W-1:0] exp_wr_data,
    input  logic [AW:0]       num_vec,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW:0]       fail_count,
    output logic [AW-1:0]     first_fail_idx,
    output logic              first_fail_vld,
    output logic [RESP_W-1:0] signature
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e            state_q;
    logic [AW-1:0]     idx_q;
    logic [AW:0]       num_q;
    logic [AW:0]       fail_q;
    logic [AW-1:0]     ffi_q;
    logic              ffv_q;
    logic [RESP_W-1:0] exp_mem [DEPTH];

    logic              xfer;
    logic              start_ok;
    logic              last;
    logic              mismatch;
    logic [AW:0]       num_clamped;

    // Handshake: a response word moves only when resp_valid && resp_ready,
    // and resp_ready is high for exactly the cycles spent in RUN.
    assign resp_ready  = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign xfer        = resp_ready && resp_valid;
    assign start_ok    = start && (state_q != ST_RUN);
    assign num_clamped = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;
    assign last        = ({1'b0, idx_q} == (num_q - 1'b1));
    assign mismatch    = (resp_data != exp_mem[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            fail_q  <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_q   <= '0;
                        fail_q  <= '0;
                        ffv_q   <= 1'b0;
                        num_q   <= num_clamped;
                        state_q <= (num_clamped == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        idx_q <= idx_q + 1'b1;
                        if (mismatch) begin
                            if (fail_q != '1) begin
                                fail_q <= fail_q + 1'b1;
                            end
                            if (!ffv_q) begin
                                ffi_q <= idx_q;
                                ffv_q <= 1'b1;
                            end
                        end
                        if (last) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Expected table is deliberately left out of reset so it survives a mid-run abort.
    always_ff @(posedge clk) begin
        if (exp_wr_en && (state_q != ST_RUN) && ({1'b0, exp_wr_addr} < DEPTH_W)) begin
            exp_mem[exp_wr_addr] <= exp_wr_data;
        end
    end

    atpg_misr #(
        .RESP_W (RESP_W)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_ok),
        .en_i   (xfer),
        .data_i (resp_data),
        .sig_o  (signature)
    );

    assign pass           = (fail_q == '0);
    assign fail_count     = fail_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_atpg_resp_checker.sv
// Directed plus randomized checks of atpg_resp_checker against a
// polynomial-arithmetic reference model of mismatch counting and the MISR.
module tb_atpg_resp_checker;

  localparam int RW = 26;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          exp_wr_en = 1'b0;
  logic [AW-1:0] exp_wr_addr = '0;
  logic [RW-1:0] exp_wr_data = '0;
  logic [AW:0]   num_vec = '0;
  logic          start = 1'b0;
  logic          resp_valid = 1'b0;
  logic [RW-1:0] resp_data = '0;
  logic          resp_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   fail_count;
  logic [AW-1:0] first_fail_idx;
  logic          first_fail_vld;
  logic [RW-1:0] signature;

  atpg_resp_checker #(.RESP_W(RW), .DEPTH(DP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exp_wr_en      (exp_wr_en),
    .exp_wr_addr    (exp_wr_addr),
    .exp_wr_data    (exp_wr_data),
    .num_vec        (num_vec),
    .start          (start),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_ready     (resp_ready),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld),
    .signature      (signature)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [RW-1:0] exp_m [DP];
  logic [RW-1:0] rsp [DP];
  logic [RW-1:0] m_sig;
  int            m_fail;
  int            m_ffi;
  bit            m_ffv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Signature update as GF(2) polynomial arithmetic: multiply by x, reduce
  // modulo x^26+x^6+x^2+x+1, then add the response word.
  function automatic logic [RW-1:0] misr_step(input logic [RW-1:0] s, input logic [RW-1:0] d);
    logic [RW:0] t;
    t = {s, 1'b0};
    if (t[RW]) t = t ^ 27'h4000047;
    return t[RW-1:0] ^ d;
  endfunction

  task automatic model_clear();
    m_sig = '0;
    m_fail = 0;
    m_ffi = 0;
    m_ffv = 1'b0;
  endtask

  task automatic load_mem(input int addr, input logic [RW-1:0] d);
    @(negedge clk);
    exp_wr_en = 1'b1;
    exp_wr_addr = AW'(addr);
    exp_wr_data = d;
    exp_m[addr] = d;
    @(negedge clk);
    exp_wr_en = 1'b0;
  endtask

  task automatic do_start(input int nv);
    @(negedge clk);
    num_vec = (AW+1)'(nv);
    start = 1'b1;
    model_clear();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends rsp[i0..i1]; n is the effective run length the run should end on.
  task automatic apply_run(input int n, input int i0, input int i1, input bit gaps);
    for (int i = i0; i <= i1; i++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          resp_valid = 1'b0;
          start = 1'($urandom_range(0, 1));
          num_vec = (AW+1)'($urandom_range(0, 16));
          exp_wr_en = 1'($urandom_range(0, 1));
          exp_wr_addr = AW'($urandom);
          exp_wr_data = RW'($urandom);
          @(negedge clk);
          start = 1'b0;
          exp_wr_en = 1'b0;
        end
      end
      resp_valid = 1'b1;
      resp_data = rsp[i];
      chk("resp_ready_run", 32'(resp_ready), 32'd1);
      if (rsp[i] != exp_m[i]) begin
        if (m_fail < 31) m_fail++;
        if (!m_ffv) begin
          m_ffv = 1'b1;
          m_ffi = i;
        end
      end
      m_sig = misr_step(m_sig, rsp[i]);
      @(negedge clk);
      chk("sig_step", 32'(signature), 32'(m_sig));
      chk("fail_step", 32'(fail_count), 32'(m_fail));
      chk("done_step", 32'(done), 32'(i == n - 1));
    end
    resp_valid = 1'b0;
  endtask

  task automatic check_final(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(resp_ready), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'(m_fail == 0));
    chk({tag, "_fcnt"}, 32'(fail_count), 32'(m_fail));
    chk({tag, "_ffv"}, 32'(first_fail_vld), 32'(m_ffv));
    if (m_ffv) chk({tag, "_ffi"}, 32'(first_fail_idx), 32'(m_ffi));
    chk({tag, "_sig"}, 32'(signature), 32'(m_sig));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(resp_ready), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd1);
    chk({tag, "_fcnt"}, 32'(fail_count), 32'd0);
    chk({tag, "_ffv"}, 32'(first_fail_vld), 32'd0);
    chk({tag, "_ffi"}, 32'(first_fail_idx), 32'd0);
    chk({tag, "_sig"}, 32'(signature), 32'd0);
  endtask

  initial begin
    int n;
    model_clear();
    for (int i = 0; i < DP; i++) begin
      exp_m[i] = '0;
      rsp[i] = '0;
    end
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("post_rst");
    for (int i = 0; i < DP; i++) load_mem(i, '0);

    // MISR directed values from a fresh signature
    rsp[0] = 26'h0000001;
    rsp[1] = 26'h0000000;
    do_start(2);
    apply_run(2, 0, 0, 1'b0);
    chk("misr_first", 32'(signature), 32'h0000001);
    apply_run(2, 1, 1, 1'b0);
    chk("misr_second", 32'(signature), 32'h0000002);
    rsp[0] = 26'h2000000;
    do_start(2);
    apply_run(2, 0, 1, 1'b0);
    chk("misr_feedback", 32'(signature), 32'h0000047);

    // All-match run
    load_mem(0, 26'h0000001);
    load_mem(1, 26'h0000002);
    load_mem(2, 26'h3FFFFFF);
    rsp[0] = 26'h0000001;
    rsp[1] = 26'h0000002;
    rsp[2] = 26'h3FFFFFF;
    do_start(3);
    apply_run(3, 0, 2, 1'b0);
    check_final("match3");
    chk("match3_pass_const", 32'(pass), 32'd1);

    // Two mismatches, first at index 1
    rsp[1] = 26'h0000000;
    rsp[2] = 26'h3FFFFFE;
    do_start(3);
    apply_run(3, 0, 2, 1'b0);
    check_final("mis3");
    chk("mis3_fcnt_const", 32'(fail_count), 32'd2);
    chk("mis3_ffi_const", 32'(first_fail_idx), 32'd1);

    // resp_valid while DONE must not move anything
    resp_valid = 1'b1;
    resp_data = 26'h1234567;
    repeat (3) @(negedge clk);
    resp_valid = 1'b0;
    check_final("done_valid");

    // Zero-length run
    do_start(0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_ready", 32'(resp_ready), 32'd0);
    chk("zero_pass", 32'(pass), 32'd1);
    chk("zero_fcnt", 32'(fail_count), 32'd0);
    @(negedge clk);
    chk("zero_ready2", 32'(resp_ready), 32'd0);

    // Randomized rounds: plain, gapped with disturbances, plain again
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DP; i++) load_mem(i, RW'($urandom));
      for (int i = 0; i < DP; i++)
        rsp[i] = ($urandom_range(0, 2) == 0) ? (exp_m[i] ^ (RW'($urandom) | 26'd1)) : exp_m[i];
      n = int'($urandom_range(1, DP));
      do_start(n);
      apply_run(n, 0, n - 1, 1'b0);
      check_final("rnd_plain");
      do_start(n);
      apply_run(n, 0, n - 1, 1'b1);
      check_final("rnd_gaps");
      do_start(n);
      apply_run(n, 0, n - 1, 1'b0);
      check_final("rnd_again");
    end

    // Oversized num_vec clamps to DEPTH
    do_start(20);
    apply_run(DP, 0, DP - 1, 1'b0);
    check_final("clamp");

    // Abort after 2 of 5 transfers, then a clean run on retained memory
    do_start(5);
    apply_run(5, 0, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    do_start(5);
    apply_run(5, 0, 4, 1'b0);
    check_final("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
